rate_limiter_arbiter: RTL and testbench
=======================================

RATE_LIMITER_ARBITER -- requirements
Module: rate_limiter_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of AXI-Stream requesters, range 2..8.
REQ-002 SHALL have parameter C_AXIS_DATA_WIDTH, default 256: tdata width; tstrb is C_AXIS_DATA_WIDTH/8.
REQ-003 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128: tuser width.
REQ-004 SHALL have port axi_aclk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port axi_areset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports s_axis_tdata/tstrb/tuser  in  NUM_PORTS*width  per-port slave payload, flattened; port i occupies slice i.
REQ-007 SHALL have ports s_axis_tvalid, s_axis_tlast  in  NUM_PORTS; s_axis_tready  out  NUM_PORTS.
REQ-008 SHALL have ports m_axis_tdata/tstrb/tuser/tvalid/tlast  out  and m_axis_tready  in; these feed the rate limiter slave port.
REQ-009 SHALL have port sw_rst  in  1  synchronous soft reset, from the register-block reset bit.
REQ-010 SHALL have port port_en  in  NUM_PORTS  per-port arbitration enable.
REQ-011 SHALL have port grant_idx  out  3  index of the port currently granted, valid while busy=1.
REQ-012 SHALL have port busy  out  1  high while a packet is being forwarded.
REQ-013 SHALL have port pkt_cnt  out  NUM_PORTS*32  per-port count of completed forwarded packets.

Function
REQ-014 SHALL implement the FSM states IDLE and PASS.
REQ-015 In IDLE, the block SHALL search the ports in round-robin order, starting at (last_grant+1) mod NUM_PORTS, for the first port i with s_axis_tvalid[i]=1 and port_en[i]=1.
REQ-016 When IDLE finds such a port, the block SHALL register grant_idx=i and set last_grant=i, and SHALL enter PASS on the next edge; this costs exactly one bubble cycle per packet.
REQ-017 In IDLE, all s_axis_tready bits SHALL be 0 and m_axis_tvalid SHALL be 0.
REQ-018 In PASS, the m_axis payload, tvalid and tlast SHALL combinationally equal the slice of the granted port, with zero-cycle latency.
REQ-019 In PASS, s_axis_tready[grant_idx] SHALL equal m_axis_tready, and all other tready bits SHALL be 0.
REQ-020 A beat with m_axis_tvalid, m_axis_tready and m_axis_tlast all high SHALL increment pkt_cnt[grant_idx] and return the FSM to IDLE on the next edge.
REQ-021 pkt_cnt SHALL wrap from 0xFFFFFFFF to 0 without saturating.
REQ-022 A change to port_en SHALL have no effect on a packet already in PASS; it applies only to the next IDLE search.
REQ-023 If no port is eligible, the FSM SHALL stay in IDLE and last_grant SHALL be unchanged.
REQ-024 When sw_rst=1 in any state, the block SHALL go to IDLE on the next edge, clear pkt_cnt and set last_grant=NUM_PORTS-1.
REQ-025 When sw_rst=1, all tready outputs and m_axis_tvalid SHALL be 0 in that same cycle; any packet in progress is truncated, and its remaining beats SHALL be arbitrated later as a new packet.
REQ-026 A port's tvalid deasserting mid-packet in PASS SHALL hold the state in PASS with m_axis_tvalid=0.

Reset
REQ-027 On axi_areset the block SHALL enter IDLE immediately, with grant_idx=0, busy=0, last_grant=NUM_PORTS-1 and all pkt_cnt=0.
REQ-028 While axi_areset is asserted, all tready outputs and m_axis_tvalid, tlast, tdata, tstrb and tuser SHALL be 0.

Structure
REQ-029 The FSM state encoding (IDLE=0, PASS=1) and the 32-bit counter width SHALL live in the shared package rate_limiter_pkg.
REQ-030 The round-robin search SHALL be implemented in one sub-module, rr_priority_select (inputs: request vector, last_grant; outputs: found, index); all other logic is flat.

Verification
REQ-031 The bench SHALL cover this case: ports 0 and 2 each present one 3-beat packet, m_axis_tready=1 -> port 0 is forwarded first, then port 2; each gets one bubble cycle; pkt_cnt = {0,1,0,1}.
REQ-032 The bench SHALL cover this case: all 4 ports continuously valid with 1-beat packets -> grant order 0,1,2,3,0; each packet is output every 2 cycles.
REQ-033 The bench SHALL cover this case: port_en=4'b1011 with port 2 valid -> port 2 is never granted and s_axis_tready[2]=0 throughout.
REQ-034 The bench SHALL cover this case: m_axis_tready toggles every cycle during a 4-beat packet from port 1 -> the beats appear unchanged and in order, tlast is on beat 4, and pkt_cnt[1] rises by 1.
REQ-035 The bench SHALL cover this case: sw_rst pulsed on beat 2 of a 4-beat packet -> the output is idle in the same cycle, then the FSM is in IDLE with pkt_cnt all zero; the next grant goes to port 0 first.
REQ-036 The bench SHALL cover this case: pkt_cnt[3] preloaded to 0xFFFFFFFF through force, then one packet completes -> pkt_cnt[3]=0.

Source files
------------

// File: rtl/rate_limiter_pkg.sv
// rtl/rate_limiter_pkg.sv - shared FSM encoding and counter width for the rate limiter arbiter
package rate_limiter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      PASS = 1'b1
   } state_t;

   localparam int CNT_W = 32;

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - round-robin first-eligible search starting after last_grant
module rr_priority_select #(
   parameter int NUM_PORTS = 4
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [2:0]           last_grant,
   output logic                 found,
   output logic [2:0]           index
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest requester after last_grant wins
   always_comb begin
      found = 1'b0;
      index = 3'd0;
      cand  = 0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         cand = (int'(last_grant) + k) % NUM_PORTS;
         for (int j = 0; j < NUM_PORTS; j++) begin
            if (req[j] && (j == cand)) begin
               found = 1'b1;
               index = 3'(j);
            end
         end
      end
   end

endmodule

// File: rtl/rate_limiter_arbiter.sv
// rtl/rate_limiter_arbiter.sv - packet-granular round-robin AXI-Stream arbiter feeding the rate limiter
module rate_limiter_arbiter
   import rate_limiter_pkg::*;
#(
   parameter int NUM_PORTS          = 4,
   parameter int C_AXIS_DATA_WIDTH  = 256,
   parameter int C_AXIS_TUSER_WIDTH = 128
) (
   input  logic                                    axi_aclk,
   input  logic                                    axi_areset,
   input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic [NUM_PORTS-1:0]                    s_axis_tvalid,
   input  logic [NUM_PORTS-1:0]                    s_axis_tlast,
   output logic [NUM_PORTS-1:0]                    s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
   output logic                                    m_axis_tvalid,
   output logic                                    m_axis_tlast,
   input  logic                                    m_axis_tready,
   input  logic                                    sw_rst,
   input  logic [NUM_PORTS-1:0]                    port_en,
   output logic [2:0]                              grant_idx,
   output logic                                    busy,
   output logic [NUM_PORTS*CNT_W-1:0]              pkt_cnt
);

   localparam int DW = C_AXIS_DATA_WIDTH;
   localparam int SW = C_AXIS_DATA_WIDTH / 8;
   localparam int UW = C_AXIS_TUSER_WIDTH;
   localparam logic [2:0]       LAST_INIT = 3'(NUM_PORTS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;

   state_t                     state_q, state_d;
   logic [2:0]                 grant_q, grant_d;
   logic [2:0]                 last_q, last_d;
   logic [NUM_PORTS*CNT_W-1:0] cnt_q;
   logic [NUM_PORTS-1:0]       eligible;
   logic                       found;
   logic [2:0]                 found_idx;
   logic                       pass_act;
   logic                       beat_done;

   // port_en is only consulted here, so a packet already granted is unaffected by it
   assign eligible = s_axis_tvalid & port_en;

   rr_priority_select #(
      .NUM_PORTS (NUM_PORTS)
   ) u_rr (
      .req        (eligible),
      .last_grant (last_q),
      .found      (found),
      .index      (found_idx)
   );

   // Soft reset closes the datapath in the very cycle it is seen
   assign pass_act  = (state_q == PASS) && !sw_rst;
   assign busy      = (state_q == PASS);
   assign grant_idx = grant_q;
   assign pkt_cnt   = cnt_q;

   // State, grant and round-robin pointer registers
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         state_q <= IDLE;
         grant_q <= 3'd0;
         last_q  <= LAST_INIT;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // Zero-latency mux of the granted slice, handshake detection and next-state selection
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tstrb  = '0;
      m_axis_tuser  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;

      if (pass_act) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == 3'(i)) begin
               m_axis_tdata     = s_axis_tdata[i*DW +: DW];
               m_axis_tstrb     = s_axis_tstrb[i*SW +: SW];
               m_axis_tuser     = s_axis_tuser[i*UW +: UW];
               m_axis_tvalid    = s_axis_tvalid[i];
               m_axis_tlast     = s_axis_tlast[i];
               s_axis_tready[i] = m_axis_tready;
            end
         end
      end

      beat_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

      if (sw_rst) begin
         state_d = IDLE;
         last_d  = LAST_INIT;
      end else begin
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_d = PASS;
                  grant_d = found_idx;
                  last_d  = found_idx;
               end
            end
            PASS: begin
               if (beat_done) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Per-port completed-packet counters, free-running with natural wrap
   always_ff @(posedge axi_aclk or posedge axi_areset) begin
      if (axi_areset) begin
         cnt_q <= '0;
      end else if (sw_rst) begin
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (beat_done && (grant_q == 3'(i))) begin
               cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_rate_limiter_arbiter.sv
// tb/tb_rate_limiter_arbiter.sv - directed self-checking bench for rate_limiter_arbiter
module tb_rate_limiter_arbiter;

   localparam int NP = 4;
   localparam int DW = 256;
   localparam int SW = DW / 8;
   localparam int UW = 128;

   logic              clk = 1'b0;
   logic              rst;
   logic [NP*DW-1:0]  s_axis_tdata;
   logic [NP*SW-1:0]  s_axis_tstrb;
   logic [NP*UW-1:0]  s_axis_tuser;
   logic [NP-1:0]     s_axis_tvalid;
   logic [NP-1:0]     s_axis_tlast;
   logic [NP-1:0]     s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic [SW-1:0]     m_axis_tstrb;
   logic [UW-1:0]     m_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic              sw_rst;
   logic [NP-1:0]     port_en;
   logic [2:0]        grant_idx;
   logic              busy;
   logic [NP*32-1:0]  pkt_cnt;
   logic [NP*32-1:0]  pre;

   int rem [NP];
   int len [NP];
   int beat[NP];
   int log_port[$], log_beat[$], log_last[$], log_cyc[$], log_user[$], log_grant[$];
   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   bit toggle;
   bit rdy2_seen;

   int e1_port[6] = '{0, 0, 0, 2, 2, 2};
   int e1_beat[6] = '{0, 1, 2, 0, 1, 2};
   int e1_last[6] = '{0, 0, 1, 0, 0, 1};
   int e1_cyc [6] = '{1, 2, 3, 5, 6, 7};
   int e5_port[4] = '{0, 3, 3, 3};
   int e5_beat[4] = '{0, 1, 2, 3};
   int e5_last[4] = '{1, 0, 0, 1};
   int e5_cyc [4] = '{1, 3, 4, 5};

   always #5 clk = ~clk;

   rate_limiter_arbiter #(
      .NUM_PORTS          (NP),
      .C_AXIS_DATA_WIDTH  (DW),
      .C_AXIS_TUSER_WIDTH (UW)
   ) dut (
      .axi_aclk      (clk),
      .axi_areset    (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .sw_rst        (sw_rst),
      .port_en       (port_en),
      .grant_idx     (grant_idx),
      .busy          (busy),
      .pkt_cnt       (pkt_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present each port's current beat: tdata = {port, beat}, tuser = {port^0x5A, beat}
   task automatic drive_src();
      for (int i = 0; i < NP; i++) begin
         s_axis_tvalid[i]          = (rem[i] > 0);
         s_axis_tlast[i]           = (rem[i] > 0) && (beat[i] == len[i] - 1);
         s_axis_tdata[i*DW +: DW]  = {240'd0, 4'd0, 4'(i), 8'(beat[i])};
         s_axis_tuser[i*UW +: UW]  = {112'd0, 8'(i) ^ 8'h5A, 8'(beat[i])};
         s_axis_tstrb[i*SW +: SW]  = 32'hFFFF_FFFF;
      end
   endtask

   task automatic clear_log();
      log_port.delete(); log_beat.delete(); log_last.delete();
      log_cyc.delete();  log_user.delete(); log_grant.delete();
   endtask

   // One clock: sample at the negedge, advance sources that handshook, return at the next negedge
   task automatic cycle();
      logic [NP-1:0] fire;
      fire = s_axis_tvalid & s_axis_tready;
      if (s_axis_tready[2]) rdy2_seen = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
         log_port.push_back(int'(m_axis_tdata[11:8]));
         log_beat.push_back(int'(m_axis_tdata[7:0]));
         log_last.push_back(int'(m_axis_tlast));
         log_cyc.push_back(cyc);
         log_user.push_back(int'(m_axis_tuser[15:0]));
         log_grant.push_back(int'(grant_idx));
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
         if (fire[i]) begin
            beat[i]++;
            if (beat[i] == len[i]) begin
               beat[i] = 0;
               rem[i]--;
            end
         end
      end
      if (toggle) m_axis_tready = ~m_axis_tready;
      drive_src();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic check_entry(input string t, input int k, input int p, input int b, input int l, input int c);
      if (k < log_port.size()) begin
         check($sformatf("%s_port%0d", t, k), log_port[k], p);
         check($sformatf("%s_beat%0d", t, k), log_beat[k], b);
         check($sformatf("%s_last%0d", t, k), log_last[k], l);
         check($sformatf("%s_user%0d", t, k), log_user[k], ((p ^ 'h5A) << 8) | b);
         check($sformatf("%s_grant%0d", t, k), log_grant[k], p);
         if (c >= 0) check($sformatf("%s_cyc%0d", t, k), log_cyc[k], c);
      end
   endtask

   initial begin
      rst = 1'b1; sw_rst = 1'b0; port_en = 4'hF; m_axis_tready = 1'b1; toggle = 1'b0;
      rdy2_seen = 1'b0; cyc = 0;
      for (int i = 0; i < NP; i++) begin rem[i] = 0; len[i] = 1; beat[i] = 0; end
      drive_src();
      s_axis_tvalid = 4'hF;
      s_axis_tlast  = 4'hF;
      repeat (2) @(negedge clk);
      check("rst_tready", s_axis_tready, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tlast",  m_axis_tlast, 0);
      check("rst_tdata",  m_axis_tdata[63:0], 0);
      check("rst_tuser",  m_axis_tuser[63:0], 0);
      check("rst_tstrb",  m_axis_tstrb, 0);
      check("rst_busy",   busy, 0);
      check("rst_grant",  grant_idx, 0);
      check("rst_cnt",    pkt_cnt == '0, 1);
      drive_src();
      rst = 1'b0;
      @(negedge clk);

      // Ports 0 and 2, one 3-beat packet each
      clear_log(); cyc = 0;
      rem[0] = 1; len[0] = 3; beat[0] = 0;
      rem[2] = 1; len[2] = 3; beat[2] = 0;
      drive_src();
      check("t1_idle_tvalid", m_axis_tvalid, 0);
      check("t1_idle_tready", s_axis_tready, 0);
      run(10);
      check("t1_nbeats", log_port.size(), 6);
      for (int k = 0; k < 6; k++) check_entry("t1", k, e1_port[k], e1_beat[k], e1_last[k], e1_cyc[k]);
      check("t1_cnt0", pkt_cnt[31:0], 1);
      check("t1_cnt1", pkt_cnt[63:32], 0);
      check("t1_cnt2", pkt_cnt[95:64], 1);
      check("t1_cnt3", pkt_cnt[127:96], 0);

      // Soft reset between tests restores the pointer so port 0 leads
      sw_rst = 1'b1;
      cycle();
      sw_rst = 1'b0;
      check("swrst_cnt_clear", pkt_cnt == '0, 1);

      // All ports continuously valid, 1-beat packets
      clear_log(); cyc = 0;
      for (int i = 0; i < NP; i++) begin rem[i] = 2; len[i] = 1; beat[i] = 0; end
      drive_src();
      run(18);
      check("t2_nbeats", log_port.size(), 8);
      for (int k = 0; k < 8; k++) check_entry("t2", k, k % 4, 0, 1, 2 * k + 1);
      for (int i = 0; i < NP; i++) check($sformatf("t2_cnt%0d", i), pkt_cnt[i*32 +: 32], 2);

      // Port 2 disabled while valid
      port_en = 4'b1011;
      clear_log(); cyc = 0; rdy2_seen = 1'b0;
      rem[2] = 1; len[2] = 2; beat[2] = 0;
      drive_src();
      run(8);
      check("t3_no_beats", log_port.size(), 0);
      check("t3_tready2_seen", rdy2_seen, 0);
      check("t3_busy", busy, 0);
      check("t3_cnt2", pkt_cnt[95:64], 2);
      rem[2] = 0;
      drive_src();
      port_en = 4'hF;

      // Port 1, 4 beats, m_axis_tready toggling
      clear_log(); cyc = 0;
      rem[1] = 1; len[1] = 4; beat[1] = 0;
      toggle = 1'b1; m_axis_tready = 1'b1;
      drive_src();
      run(12);
      toggle = 1'b0; m_axis_tready = 1'b1;
      check("t4_nbeats", log_port.size(), 4);
      for (int k = 0; k < 4; k++) check_entry("t4", k, 1, k, (k == 3) ? 1 : 0, -1);
      check("t4_cnt1", pkt_cnt[63:32], 3);

      // Soft reset on beat 2 of a 4-beat packet from port 3
      clear_log(); cyc = 0;
      rem[3] = 1; len[3] = 4; beat[3] = 0;
      drive_src();
      run(2);
      check("t5_beat2_valid", m_axis_tvalid, 1);
      check("t5_beat2_data", m_axis_tdata[11:0], 12'h301);
      sw_rst = 1'b1;
      #1;
      check("t5_swrst_tvalid", m_axis_tvalid, 0);
      check("t5_swrst_tready", s_axis_tready, 0);
      rem[0] = 1; len[0] = 1; beat[0] = 0;
      drive_src();
      #1;
      check("t5_swrst_tready_p0", s_axis_tready, 0);
      cycle();
      sw_rst = 1'b0;
      check("t5_idle_busy", busy, 0);
      check("t5_cnt_clear", pkt_cnt == '0, 1);
      clear_log(); cyc = 0;
      run(10);
      check("t5_nbeats", log_port.size(), 4);
      for (int k = 0; k < 4; k++) check_entry("t5", k, e5_port[k], e5_beat[k], e5_last[k], e5_cyc[k]);
      check("t5_cnt0", pkt_cnt[31:0], 1);
      check("t5_cnt3", pkt_cnt[127:96], 1);

      // Counter wrap on port 3
      pre = {32'hFFFF_FFFF, pkt_cnt[95:0]};
      force dut.cnt_q = pre;
      #1;
      release dut.cnt_q;
      #1;
      check("t6_preload", pkt_cnt[127:96], 32'hFFFF_FFFF);
      clear_log(); cyc = 0;
      rem[3] = 1; len[3] = 1; beat[3] = 0;
      drive_src();
      run(5);
      check("t6_nbeats", log_port.size(), 1);
      check("t6_cnt3_wrap", pkt_cnt[127:96], 0);
      check("t6_cnt0_keep", pkt_cnt[31:0], 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
